uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
Downstream consumer of the UART engine's RX FIFO. It reads received bytes from the FIFO's read port and parses the command frame HEAD0 HEAD1 CMD LEN PAYLOAD[LEN] CHK. Payload bytes stream out with the command byte attached, and each frame ends with a done/error report. It sits between the RX FIFO and the register/command decoder.

Parameters:
HEAD0, 8'h55, first header byte
HEAD1, 8'hAA, second header byte
MAX_LEN, 16, largest legal LEN value (range 1..255)
TIMEOUT_CYCLES, 500000, idle sys_clk_i cycles allowed between bytes inside a frame (10 ms at 50 MHz)

Ports:
sys_clk_i  in  1  system clock, same domain as the UART engine
rst_n_i  in  1  asynchronous active-low reset
fifo_rd_en_o  out  1  RX FIFO read strobe
fifo_dout_valid_i  in  1  RX FIFO data valid, one cycle after fifo_rd_en_o
fifo_dout_i  in  8  RX FIFO read data
fifo_empty_i  in  1  RX FIFO empty
frame_cmd_o  out  8  CMD byte of the current/last frame
frame_len_o  out  8  LEN byte of the current/last frame
frame_data_o  out  8  payload byte
frame_data_valid_o  out  1  one-cycle strobe per payload byte
frame_data_last_o  out  1  qualifies frame_data_valid_o on the final payload byte
frame_done_o  out  1  one-cycle strobe at frame end (good or bad)
frame_err_o  out  1  valid with frame_done_o; 1 = frame bad
frame_err_code_o  out  2  0 ok, 1 checksum, 2 length, 3 timeout; held until next frame_done_o
frame_err_cnt_o  out  8  count of bad frames, saturates at 255

Behaviour:
- Reset (async, rst_n_i=0): all outputs 0, FSM in IDLE, byte counter, checksum, timeout counter and read-outstanding flag all 0.
- FIFO read handshake:
  - fifo_rd_en_o is registered and asserts for exactly one cycle when fifo_empty_i=0 and no read is outstanding.
  - A read is outstanding from the fifo_rd_en_o cycle until the cycle fifo_dout_valid_i=1.
  - At most one byte every 2 cycles.
  - A byte is consumed in the cycle fifo_dout_valid_i=1.
  - fifo_dout_valid_i while no read is outstanding is ignored.
- FSM states: IDLE, HDR1, CMD, LEN, DATA, CHK.
  - IDLE: byte==HEAD0 -> HDR1; any other byte is discarded and the FSM stays in IDLE.
  - HDR1: byte==HEAD1 -> CMD; byte==HEAD0 -> stay HDR1 (resync); else -> IDLE.
  - CMD: latch frame_cmd_o, checksum<=byte -> LEN.
  - LEN: latch frame_len_o, checksum+=byte.
    - LEN==0 -> CHK.
    - LEN>MAX_LEN -> length error, -> IDLE.
    - Otherwise byte counter<=LEN -> DATA.
  - DATA: checksum+=byte, frame_data_o<=byte, frame_data_valid_o=1 next cycle, counter-1. The counter reaching 0 sets frame_data_last_o with that strobe, then -> CHK.
  - CHK: byte==checksum -> ok, else checksum error; -> IDLE.
- Checksum: 8-bit sum of CMD, LEN and all payload bytes, modulo 256 (carry dropped).
- Frame end:
  - frame_done_o pulses for one cycle, on the cycle after the terminating byte (or the timeout) is consumed.
  - frame_err_o and frame_err_code_o update in that same cycle.
  - Length errors terminate in the cycle after the LEN byte; the payload is not consumed and is then hunted through as garbage.
- Timeout:
  - In HDR1..CHK, the timeout counter increments each cycle with no byte consumed and clears on each consumed byte.
  - Reaching TIMEOUT_CYCLES-1 -> error code 3, frame_done_o, -> IDLE.
  - No timeout in IDLE.
- Error counter: +1 on each frame_done_o with frame_err_o=1; holds at 255.
- Payload is streamed before the checksum is checked. Consumers must buffer it and discard it when frame_err_o=1.
- A byte consumed in the same cycle as the timeout fires is processed in IDLE, i.e. it is treated as a hunt byte.
- Reset mid-frame: immediate return to IDLE, and no frame_done_o is emitted. An outstanding FIFO read is abandoned, so its byte is lost.
- Latency: a payload byte appears on frame_data_o 1 cycle after fifo_dout_valid_i.

Test Plan:
- Good frame: 55 AA 10 03 01 02 03 19 -> 3 data strobes 01,02,03, last on 03; frame_cmd_o=10; frame_done_o=1, frame_err_o=0, code 0, err_cnt 0.
- Bad checksum: 55 AA 10 03 01 02 03 18 -> 3 data strobes, then frame_done_o with err=1, code 1, err_cnt=1.
- Zero length and resync: 00 55 55 AA 20 00 20 -> no data strobes; done with err=0; cmd=20; leading 00 and extra 55 ignored.
- Length error (MAX_LEN=16): 55 AA 01 11 ... -> done err=1, code 2 right after the LEN byte; a following good frame still parses with err=0.
- Timeout (TIMEOUT_CYCLES=100): 55 AA 10 then FIFO empty for 100 cycles -> done err=1, code 3; the next byte 55 enters HDR1.
- Reset mid-frame after 55 AA 10 03 01 -> all outputs 0, no done pulse; a subsequent good frame parses correctly; err_cnt stays 0.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Command frame parser sitting on the RX FIFO read port.
// Parses HEAD0 HEAD1 CMD LEN PAYLOAD[LEN] CHK, streams payload and reports each frame end.
`timescale 1ns/1ps

module uart_frame_parser #(
  parameter logic [7:0]  HEAD0          = 8'h55,
  parameter logic [7:0]  HEAD1          = 8'hAA,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic       sys_clk_i,
  input  logic       rst_n_i,
  output logic       fifo_rd_en_o,
  input  logic       fifo_dout_valid_i,
  input  logic [7:0] fifo_dout_i,
  input  logic       fifo_empty_i,
  output logic [7:0] frame_cmd_o,
  output logic [7:0] frame_len_o,
  output logic [7:0] frame_data_o,
  output logic       frame_data_valid_o,
  output logic       frame_data_last_o,
  output logic       frame_done_o,
  output logic       frame_err_o,
  output logic [1:0] frame_err_code_o,
  output logic [7:0] frame_err_cnt_o
);

  // state | meaning
  // IDLE  | hunting for HEAD0, no timeout
  // HDR1  | HEAD0 seen, expecting HEAD1 (HEAD0 repeats resync here)
  // CMD   | expecting command byte
  // LEN   | expecting length byte
  // DATA  | streaming payload, byte_cnt_q bytes still to come
  // CHK   | expecting checksum byte
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  localparam int unsigned     TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  logic [2:0]      state_q;
  logic            rd_pend_q;
  logic [7:0]      byte_cnt_q;
  logic [7:0]      chk_q;
  logic [TO_W-1:0] to_cnt_q;

  logic            byte_vld;
  logic            rd_launch;
  logic            to_fire;
  logic            fin;
  logic [1:0]      fin_code;

  // Data arriving without an outstanding read is not ours and is dropped.
  assign byte_vld  = fifo_dout_valid_i & rd_pend_q;
  assign rd_launch = ~rd_pend_q & ~fifo_empty_i;
  assign to_fire   = (state_q != S_IDLE) && (to_cnt_q == TO_LAST);

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fifo_rd_en_o <= 1'b0;
      rd_pend_q    <= 1'b0;
    end else begin
      fifo_rd_en_o <= rd_launch;
      if (rd_launch) begin
        rd_pend_q <= 1'b1;
      end else if (byte_vld) begin
        rd_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      to_cnt_q <= '0;
    end else if ((state_q == S_IDLE) || byte_vld || to_fire) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  always_comb begin
    fin      = 1'b0;
    fin_code = ERR_OK;
    if (to_fire) begin
      fin      = 1'b1;
      fin_code = ERR_TIMEOUT;
    end else if (byte_vld) begin
      case (state_q)
        S_LEN: begin
          if (fifo_dout_i > MAX_LEN_B) begin
            fin      = 1'b1;
            fin_code = ERR_LEN;
          end
        end
        S_CHK: begin
          fin      = 1'b1;
          fin_code = (fifo_dout_i == chk_q) ? ERR_OK : ERR_CHK;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q            <= S_IDLE;
      byte_cnt_q         <= '0;
      chk_q              <= '0;
      frame_cmd_o        <= '0;
      frame_len_o        <= '0;
      frame_data_o       <= '0;
      frame_data_valid_o <= 1'b0;
      frame_data_last_o  <= 1'b0;
    end else begin
      frame_data_valid_o <= 1'b0;
      frame_data_last_o  <= 1'b0;
      if (to_fire) begin
        // A byte landing in the timeout cycle is treated as a hunt byte.
        state_q <= (byte_vld && (fifo_dout_i == HEAD0)) ? S_HDR1 : S_IDLE;
      end else if (byte_vld) begin
        case (state_q)
          S_IDLE: begin
            if (fifo_dout_i == HEAD0) state_q <= S_HDR1;
          end
          S_HDR1: begin
            if (fifo_dout_i == HEAD1) begin
              state_q <= S_CMD;
            end else if (fifo_dout_i != HEAD0) begin
              state_q <= S_IDLE;
            end
          end
          S_CMD: begin
            frame_cmd_o <= fifo_dout_i;
            chk_q       <= fifo_dout_i;
            state_q     <= S_LEN;
          end
          S_LEN: begin
            frame_len_o <= fifo_dout_i;
            chk_q       <= chk_q + fifo_dout_i;
            byte_cnt_q  <= fifo_dout_i;
            if (fifo_dout_i == 8'd0) begin
              state_q <= S_CHK;
            end else if (fifo_dout_i > MAX_LEN_B) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            chk_q              <= chk_q + fifo_dout_i;
            frame_data_o       <= fifo_dout_i;
            frame_data_valid_o <= 1'b1;
            frame_data_last_o  <= (byte_cnt_q == 8'd1);
            byte_cnt_q         <= byte_cnt_q - 8'd1;
            if (byte_cnt_q == 8'd1) state_q <= S_CHK;
          end
          S_CHK: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_done_o     <= 1'b0;
      frame_err_o      <= 1'b0;
      frame_err_code_o <= ERR_OK;
      frame_err_cnt_o  <= '0;
    end else begin
      frame_done_o <= fin;
      if (fin) begin
        frame_err_o      <= (fin_code != ERR_OK);
        frame_err_code_o <= fin_code;
        if ((fin_code != ERR_OK) && (frame_err_cnt_o != 8'hFF)) begin
          frame_err_cnt_o <= frame_err_cnt_o + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized scoreboard bench for uart_frame_parser: a byte-stream parser model
// predicts payload strobes and frame reports, a monitor compares them as they appear.
`timescale 1ns/1ps

module tb_uart_frame_parser;

  localparam int          MAX_LEN = 16;
  localparam int          TO_CYC  = 100;
  localparam logic [7:0]  H0      = 8'h55;
  localparam logic [7:0]  H1      = 8'hAA;

  logic       sys_clk_i = 1'b0;
  logic       rst_n_i   = 1'b0;
  logic       fifo_rd_en_o;
  logic       fifo_dout_valid_i;
  logic [7:0] fifo_dout_i;
  logic       fifo_empty_i;
  logic [7:0] frame_cmd_o;
  logic [7:0] frame_len_o;
  logic [7:0] frame_data_o;
  logic       frame_data_valid_o;
  logic       frame_data_last_o;
  logic       frame_done_o;
  logic       frame_err_o;
  logic [1:0] frame_err_code_o;
  logic [7:0] frame_err_cnt_o;

  uart_frame_parser #(
    .HEAD0          (H0),
    .HEAD1          (H1),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .sys_clk_i          (sys_clk_i),
    .rst_n_i            (rst_n_i),
    .fifo_rd_en_o       (fifo_rd_en_o),
    .fifo_dout_valid_i  (fifo_dout_valid_i),
    .fifo_dout_i        (fifo_dout_i),
    .fifo_empty_i       (fifo_empty_i),
    .frame_cmd_o        (frame_cmd_o),
    .frame_len_o        (frame_len_o),
    .frame_data_o       (frame_data_o),
    .frame_data_valid_o (frame_data_valid_o),
    .frame_data_last_o  (frame_data_last_o),
    .frame_done_o       (frame_done_o),
    .frame_err_o        (frame_err_o),
    .frame_err_code_o   (frame_err_code_o),
    .frame_err_cnt_o    (frame_err_cnt_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] data; logic last; logic [7:0] cmd; } data_ev_t;
  typedef struct { logic [1:0] code; logic [7:0] cnt; logic [7:0] cmd; logic [7:0] len; } done_ev_t;

  logic [7:0] fifo_q[$];
  data_ev_t   exp_data[$];
  done_ev_t   exp_done[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_cmd    = 8'h00;
  logic [7:0] m_len    = 8'h00;
  logic [7:0] m_errcnt = 8'h00;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push_data(input logic [7:0] d, input logic last);
    data_ev_t e;
    e.data = d;
    e.last = last;
    e.cmd  = m_cmd;
    exp_data.push_back(e);
  endfunction

  function automatic void push_done(input logic [1:0] code);
    done_ev_t e;
    if (code != 2'd0 && m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
    e.code = code;
    e.cnt  = m_errcnt;
    e.cmd  = m_cmd;
    e.len  = m_len;
    exp_done.push_back(e);
  endfunction

  // Walks a contiguous byte stream frame by frame; gap=1 means a long silence follows.
  function automatic void model_seg(input bq_t seg, input bit gap);
    int n;
    int i;
    int k;
    bit open;
    logic [7:0] len;
    logic [7:0] sum;
    n = seg.size();
    i = 0;
    open = 1'b0;
    len = 8'h00;
    sum = 8'h00;
    while (i < n) begin
      if (seg[i] != H0) begin
        i++;
        continue;
      end
      open = 1'b1;
      i++;
      while (i < n && seg[i] == H0) i++;
      if (i >= n) break;
      if (seg[i] != H1) begin
        open = 1'b0;
        i++;
        continue;
      end
      i++;
      if (i >= n) break;
      m_cmd = seg[i];
      sum = seg[i];
      i++;
      if (i >= n) break;
      len = seg[i];
      m_len = len;
      sum = sum + len;
      i++;
      if (int'(len) > MAX_LEN) begin
        push_done(2'd2);
        open = 1'b0;
        continue;
      end
      k = 0;
      while (k < int'(len) && i < n) begin
        push_data(seg[i], k == int'(len) - 1);
        sum = sum + seg[i];
        i++;
        k++;
      end
      if (i >= n) break;
      push_done((seg[i] == sum) ? 2'd0 : 2'd1);
      open = 1'b0;
      i++;
    end
    if (open && gap) push_done(2'd3);
  endfunction

  // RX FIFO: answers each read strobe with valid data one cycle later.
  initial begin
    fifo_dout_valid_i = 1'b0;
    fifo_dout_i       = 8'h00;
    fifo_empty_i      = 1'b1;
    forever begin
      @(posedge sys_clk_i);
      #1;
      if (rst_n_i && fifo_rd_en_o && fifo_q.size() > 0) begin
        fifo_dout_i       = fifo_q.pop_front();
        fifo_dout_valid_i = 1'b1;
      end else begin
        fifo_dout_valid_i = 1'b0;
      end
      fifo_empty_i = (fifo_q.size() == 0);
    end
  end

  initial begin
    data_ev_t de;
    done_ev_t fe;
    forever begin
      @(negedge sys_clk_i);
      if (frame_data_valid_o === 1'b1) begin
        if (exp_data.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_data: got %0h with no payload byte expected", frame_data_o);
        end else begin
          de = exp_data.pop_front();
          check("data_byte", 32'(frame_data_o), 32'(de.data));
          check("data_last", 32'(frame_data_last_o), 32'(de.last));
          check("data_cmd",  32'(frame_cmd_o), 32'(de.cmd));
        end
      end
      if (frame_done_o === 1'b1) begin
        if (exp_done.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got code %0d with no frame end expected", frame_err_code_o);
        end else begin
          fe = exp_done.pop_front();
          check("done_err",    32'(frame_err_o), 32'(fe.code != 2'd0));
          check("done_code",   32'(frame_err_code_o), 32'(fe.code));
          check("done_errcnt", 32'(frame_err_cnt_o), 32'(fe.cnt));
          check("done_cmd",    32'(frame_cmd_o), 32'(fe.cmd));
          check("done_len",    32'(frame_len_o), 32'(fe.len));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic feed(input bq_t seg);
    foreach (seg[i]) begin
      repeat ($urandom_range(0, 3)) @(posedge sys_clk_i);
      fifo_q.push_back(seg[i]);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((fifo_q.size() != 0 || fifo_dout_valid_i) && k < 4000) begin
      @(posedge sys_clk_i);
      k++;
    end
    if (k >= 4000) check("fifo_drained", 32'(fifo_q.size()), 32'd0);
    repeat (4) @(posedge sys_clk_i);
  endtask

  task automatic run_seg(input bq_t seg, input bit gap);
    model_seg(seg, gap);
    feed(seg);
    drain();
    if (gap) repeat (TO_CYC + 20) @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    check("pending_data", 32'(exp_data.size()), 32'd0);
    check("pending_done", 32'(exp_done.size()), 32'd0);
    exp_data.delete();
    exp_done.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},  32'(fifo_rd_en_o), 32'd0);
    check({tag, "_cmd"},    32'(frame_cmd_o), 32'd0);
    check({tag, "_len"},    32'(frame_len_o), 32'd0);
    check({tag, "_data"},   32'(frame_data_o), 32'd0);
    check({tag, "_valid"},  32'(frame_data_valid_o), 32'd0);
    check({tag, "_last"},   32'(frame_data_last_o), 32'd0);
    check({tag, "_done"},   32'(frame_done_o), 32'd0);
    check({tag, "_err"},    32'(frame_err_o), 32'd0);
    check({tag, "_code"},   32'(frame_err_code_o), 32'd0);
    check({tag, "_errcnt"}, 32'(frame_err_cnt_o), 32'd0);
  endtask

  task automatic gen_frame(inout bq_t seg, input bit allow_trunc);
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] sum;
    logic [7:0] b;
    int garbage;
    int cut;
    if ($urandom_range(0, 3) == 0) begin
      garbage = $urandom_range(1, 3);
      for (int g = 0; g < garbage; g++) seg.push_back(8'($urandom_range(0, 255)));
    end
    seg.push_back(H0);
    if ($urandom_range(0, 4) == 0) seg.push_back(H0);
    seg.push_back(H1);
    cmd = 8'($urandom_range(0, 255));
    len = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(MAX_LEN + 1, MAX_LEN + 4))
                                      : 8'($urandom_range(0, MAX_LEN));
    seg.push_back(cmd);
    seg.push_back(len);
    sum = cmd + len;
    for (int p = 0; p < int'(len) && p < MAX_LEN; p++) begin
      b = 8'($urandom_range(0, 255));
      seg.push_back(b);
      sum = sum + b;
    end
    seg.push_back(($urandom_range(0, 4) == 0) ? (sum ^ 8'h01) : sum);
    if (allow_trunc && $urandom_range(0, 5) == 0) begin
      cut = $urandom_range(1, 3);
      for (int c = 0; c < cut && seg.size() > 0; c++) void'(seg.pop_back());
    end
  endtask

  initial begin
    bq_t seg;
    int nfr;

    rst_n_i = 1'b0;
    repeat (3) @(negedge sys_clk_i);
    check_reset_outputs("reset");
    rst_n_i = 1'b1;
    repeat (2) @(negedge sys_clk_i);

    seg = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    run_seg(seg, 1'b1);
    seg = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18};
    run_seg(seg, 1'b1);
    seg = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h20, 8'h00, 8'h20};
    run_seg(seg, 1'b1);
    seg = '{8'h55, 8'hAA, 8'h01, 8'h11, 8'h00, 8'h01, 8'h02,
            8'h55, 8'hAA, 8'h30, 8'h01, 8'h7F, 8'hB0};
    run_seg(seg, 1'b1);
    seg = '{8'h55, 8'hAA, 8'h01, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h89};
    run_seg(seg, 1'b1);
    seg = '{8'h55, 8'hAA, 8'h10};
    run_seg(seg, 1'b1);
    seg = '{8'h55, 8'hAA, 8'h10, 8'h02, 8'h05, 8'h06, 8'h1D};
    run_seg(seg, 1'b1);

    seg = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01};
    run_seg(seg, 1'b0);
    @(negedge sys_clk_i);
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    m_cmd = 8'h00;
    m_len = 8'h00;
    m_errcnt = 8'h00;
    repeat (2) @(negedge sys_clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge sys_clk_i);
    seg = '{8'h55, 8'hAA, 8'h42, 8'h01, 8'hFF, 8'h42};
    run_seg(seg, 1'b1);

    for (int s = 0; s < 25; s++) begin
      seg = {};
      nfr = $urandom_range(1, 3);
      for (int f = 0; f < nfr; f++) gen_frame(seg, f == nfr - 1);
      run_seg(seg, 1'b1);
    end

    seg = {};
    for (int f = 0; f < 260; f++) begin
      seg.push_back(H0);
      seg.push_back(H1);
      seg.push_back(8'h00);
      seg.push_back(8'h00);
      seg.push_back(8'h01);
    end
    run_seg(seg, 1'b1);
    seg = '{8'h55, 8'hAA, 8'h05, 8'h01, 8'h0A, 8'h10};
    run_seg(seg, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
